xnor_lfsr_gen: RTL and testbench
================================

# xnor_lfsr_gen

XNOR-feedback Fibonacci LFSR that produces a pseudo-random serial bit stream over a valid/ready handshake. It feeds the bitwise XNOR comparator stage in the basic test path, which compares a received stream against this locally generated reference. The block supports a seed load and an enable, recovers from the all-ones lock-up state, and counts accepted bits to flag each full sequence period.

## Interface
- `WIDTH`, default 8: LFSR length in bits (minimum 3).
- `TAPS`, default 8'hB8: feedback tap mask; bit i set means state[i] enters the XNOR feedback. The default is the maximal-length x^8+x^6+x^5+x^4+1.
- `SEED`, default 0: reset seed. It also replaces any all-ones seed.
- `clk` in 1: the single clock. All state is updated on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `en` in 1: run request.
- `load` in 1: synchronous seed load. It has priority over everything except reset.
- `seed_in` in WIDTH: seed value, sampled when `load`=1.
- `out_ready` in 1: sink can accept `out_bit`.
- `out_valid` out 1: `out_bit` is valid.
- `out_bit` out 1: current stream bit, equal to state[WIDTH-1].
- `state` out WIDTH: current LFSR register.
- `step_cnt` out WIDTH: number of transfers since the last load or reset, modulo 2^WIDTH-1.
- `wrap` out 1: one-cycle pulse when a full period completes.
- `lockup` out 1: one-cycle pulse when an all-ones seed is rejected.

## Operation
- Feedback: fb = ~^(state & TAPS). Next state = {state[WIDTH-2:0], fb}. All-ones is the only lock-up state; all-zeros is legal.
- A transfer happens when `out_valid` && `out_ready`. Each transfer advances the LFSR by exactly one step. No other event advances it.
- FSM states and transitions:
  - IDLE: `out_valid`=0. Moves to RUN when `en`=1.
  - RUN: `out_valid`=1 unless `load`=1. If `en`=0 with no transfer in the same cycle, moves to DRAIN. If `en`=0 with a transfer, moves to IDLE.
  - DRAIN: `out_valid` is held at 1 until a transfer, then moves to IDLE. This keeps `out_valid` stable once raised. If `en` returns to 1 during DRAIN, the FSM goes back to RUN.
- Load:
  - state <= seed_in, step_cnt <= 0, and the FSM goes to RUN if `en`=1, otherwise IDLE.
  - If seed_in is all-ones, state <= SEED instead and `lockup` pulses on the next cycle.
  - `out_valid` is forced to 0 in the load cycle (combinational gate). The load is the only permitted withdrawal of `out_valid`.
- Counter: `step_cnt` increments on each transfer. A transfer at 2^WIDTH-2 wraps it to 0 and pulses `wrap` on the next cycle.
- `state`, `step_cnt` and the FSM hold their values in IDLE.

## Timing
- Reset values: state=SEED, FSM=IDLE, `out_valid`=0, `out_bit`=SEED[WIDTH-1], `step_cnt`=0, `wrap`=0, `lockup`=0. Reset takes effect immediately, including mid-stream; a pending bit is discarded.
- `en` rising in cycle N gives `out_valid`=1 from cycle N+1.
- A transfer in cycle N presents the next `out_bit` in cycle N+1. With `out_ready` held high the throughput is 1 bit per cycle.
- `load` in cycle N gives the new state at cycle N+1, and `lockup`/`wrap` register at N+1.
- `load` and `out_ready` in the same cycle: there is no transfer, the load is applied, and `step_cnt`=0.
- `wrap` and `load` in the same cycle: the load wins and `wrap` does not pulse.

## Structure
- `lfsr_pkg` holds:
  - the FSM state enum (IDLE, RUN, DRAIN);
  - the default tap constants for widths 3 to 16;
  - the `lfsr_all_ones(width)` helper.
- One sub-module, `lfsr_feedback`: the masked XNOR reduction, WIDTH inputs to 1 output, built from `xnor` primitives.
- The top level contains the register, FSM, counter and handshake logic.

## Test plan
- Sequence after reset: WIDTH=8, SEED=0, `en`=1, `out_ready`=1. Expect `state` 00, 01, 03, 07, 0F, 1E on consecutive cycles and `out_bit` 0,0,0,0,0,0.
- Backpressure: `out_ready` toggled randomly. Expect that `state` advances only on transfers, `out_valid` never drops while waiting, and `out_bit` holds.
- Lock-up seed: `load`=1 with `seed_in`=FF. Expect `state`=00 next cycle and a single-cycle `lockup` pulse. `load` with `seed_in`=5A gives `state`=5A and no pulse.
- Period: run 255 transfers from seed 00. Expect `state` back at 00, `wrap` pulsing exactly once (the cycle after transfer 255), `step_cnt`=0, and no all-ones state seen.
- Enable drain: in RUN with `out_ready`=0, drop `en`. Expect `out_valid` held at 1, then one transfer, then IDLE with `out_valid`=0 and `state` frozen.
- Async reset mid-stream: assert `rst_n`=0 between clock edges. Expect all outputs at reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the XNOR LFSR generator.
// Holds the FSM encoding, default tap masks and the all-ones helper.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } lfsr_fsm_e;

    // Maximal-length XNOR taps; bit i set means state[i] feeds back.
    localparam logic [15:0] TAPS_W3  = 16'h0006;
    localparam logic [15:0] TAPS_W4  = 16'h000C;
    localparam logic [15:0] TAPS_W5  = 16'h0014;
    localparam logic [15:0] TAPS_W6  = 16'h0030;
    localparam logic [15:0] TAPS_W7  = 16'h0060;
    localparam logic [15:0] TAPS_W8  = 16'h00B8;
    localparam logic [15:0] TAPS_W9  = 16'h0110;
    localparam logic [15:0] TAPS_W10 = 16'h0240;
    localparam logic [15:0] TAPS_W11 = 16'h0500;
    localparam logic [15:0] TAPS_W12 = 16'h0829;
    localparam logic [15:0] TAPS_W13 = 16'h100D;
    localparam logic [15:0] TAPS_W14 = 16'h2015;
    localparam logic [15:0] TAPS_W15 = 16'h6000;
    localparam logic [15:0] TAPS_W16 = 16'hD008;

    function automatic logic [15:0] lfsr_default_taps(input int width);
        case (width)
            3:       return TAPS_W3;
            4:       return TAPS_W4;
            5:       return TAPS_W5;
            6:       return TAPS_W6;
            7:       return TAPS_W7;
            8:       return TAPS_W8;
            9:       return TAPS_W9;
            10:      return TAPS_W10;
            11:      return TAPS_W11;
            12:      return TAPS_W12;
            13:      return TAPS_W13;
            14:      return TAPS_W14;
            15:      return TAPS_W15;
            16:      return TAPS_W16;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_all_ones(input int width);
        if (width >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/xnor_lfsr_gen_feedback.sv
// Masked XNOR reduction for the LFSR feedback bit.
// Computes ~^(state & TAPS) as a chain of xnor primitives.
module lfsr_feedback #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = '0
) (
    input  logic [WIDTH-1:0] i_state,
    output logic             o_fb
);

    logic [WIDTH-1:0] w_m;
    logic [WIDTH:0]   w_c;

    assign w_m = i_state & TAPS;

    // Each xnor stage adds an inversion; the chain seed cancels the
    // extra ones so the result is the inverted parity for any WIDTH.
    assign w_c[0] = ((WIDTH % 2) == 0);

    for (genvar i = 0; i < WIDTH; i++) begin : g_x
        xnor u_x (w_c[i+1], w_c[i], w_m[i]);
    end

    assign o_fb = w_c[WIDTH];

endmodule

// File: rtl/xnor_lfsr_gen.sv
// XNOR Fibonacci LFSR bit source with valid/ready output,
// seed load, lock-up recovery and period counter.
module xnor_lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] step_cnt,
    output logic             wrap,
    output logic             lockup
);

    localparam logic [WIDTH-1:0] ONES     = WIDTH'(lfsr_all_ones(WIDTH));
    localparam logic [WIDTH-1:0] CNT_LAST = ONES - WIDTH'(1);

    lfsr_fsm_e        r_fsm;
    lfsr_fsm_e        w_fsm_nxt;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic             r_lockup;
    logic             w_fb;
    logic             w_valid;
    logic             w_xfer;
    logic             w_seed_ones;

    lfsr_feedback #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_fb (
        .i_state (r_state),
        .o_fb    (w_fb)
    );

    // Load withdraws valid for its own cycle so it can never collide
    // with a transfer.
    assign w_valid     = (r_fsm != ST_IDLE) && !load;
    assign w_xfer      = w_valid && out_ready;
    assign w_seed_ones = (seed_in == ONES);

    always_comb begin
        w_fsm_nxt = r_fsm;
        if (load) begin
            w_fsm_nxt = en ? ST_RUN : ST_IDLE;
        end else begin
            unique case (r_fsm)
                ST_IDLE: begin
                    if (en) w_fsm_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (!en) w_fsm_nxt = w_xfer ? ST_IDLE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (en)          w_fsm_nxt = ST_RUN;
                    else if (w_xfer) w_fsm_nxt = ST_IDLE;
                end
                default: w_fsm_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm    <= ST_IDLE;
            r_state  <= SEED;
            r_cnt    <= '0;
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_fsm    <= w_fsm_nxt;
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
            if (load) begin
                r_state  <= w_seed_ones ? SEED : seed_in;
                r_cnt    <= '0;
                r_lockup <= w_seed_ones;
            end else if (w_xfer) begin
                r_state <= {r_state[WIDTH-2:0], w_fb};
                if (r_cnt == CNT_LAST) begin
                    r_cnt  <= '0;
                    r_wrap <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + WIDTH'(1);
                end
            end
        end
    end

    assign out_valid = w_valid;
    assign out_bit   = r_state[WIDTH-1];
    assign state     = r_state;
    assign step_cnt  = r_cnt;
    assign wrap      = r_wrap;
    assign lockup    = r_lockup;

endmodule

// File: tb/tb_xnor_lfsr_gen.sv
// Self-checking bench for xnor_lfsr_gen (WIDTH=8, SEED=0).
// Random stimulus checked against a behavioural stream model.
module tb_xnor_lfsr_gen;

    localparam logic [7:0] SEED = 8'h00;
    localparam logic [7:0] TAPS = 8'hB8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic       out_bit;
    logic [7:0] state;
    logic [7:0] step_cnt;
    logic       wrap;
    logic       lockup;

    int n_tests = 0;
    int n_fail  = 0;

    logic       m_busy;
    logic [7:0] m_state;
    logic [7:0] m_cnt;
    logic       m_wrap;
    logic       m_lock;
    logic       m_xfer;
    logic       pre_valid_dut;
    logic       pre_valid_exp;

    xnor_lfsr_gen #(
        .WIDTH (8),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .seed_in   (seed_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .state     (state),
        .step_cnt  (step_cnt),
        .wrap      (wrap),
        .lockup    (lockup)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Next LFSR value from the polynomial: new bit is 1 when the
    // tapped bits hold an even number of ones.
    function automatic logic [7:0] model_next(input logic [7:0] s);
        logic fb;
        fb = (($countones(s & TAPS) % 2) == 0);
        return {s[6:0], fb};
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_state = SEED;
        m_cnt   = 8'd0;
        m_wrap  = 1'b0;
        m_lock  = 1'b0;
    endtask

    // One clock: drive inputs, sample combinational valid before the
    // edge, then advance the model and land at posedge+1.
    task automatic cycle(input logic e, input logic l, input logic r,
                         input logic [7:0] s);
        en = e; load = l; out_ready = r; seed_in = s;
        #1;
        pre_valid_dut = out_valid;
        pre_valid_exp = m_busy && !l;
        m_xfer = pre_valid_exp && r;
        @(posedge clk);
        #1;
        m_wrap = 1'b0;
        m_lock = 1'b0;
        if (l) begin
            if (s == 8'hFF) begin
                m_state = SEED;
                m_lock  = 1'b1;
            end else begin
                m_state = s;
            end
            m_cnt  = 8'd0;
            m_busy = e;
        end else begin
            if (m_xfer) begin
                m_state = model_next(m_state);
                if (m_cnt == 8'd254) begin
                    m_cnt  = 8'd0;
                    m_wrap = 1'b1;
                end else begin
                    m_cnt = m_cnt + 8'd1;
                end
            end
            if (!m_busy)  m_busy = e;
            else if (!e)  m_busy = !m_xfer;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 0; load = 0; out_ready = 0; seed_in = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        n_tests++;
        if (state !== SEED) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", state, SEED);
        end
        n_tests++;
        if (out_valid !== 1'b0 || out_bit !== SEED[7]) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b bit=%b want 0/%b",
                     out_valid, out_bit, SEED[7]);
        end
        n_tests++;
        if (step_cnt !== 8'd0 || wrap !== 1'b0 || lockup !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: cnt=%0d wrap=%b lockup=%b want 0/0/0",
                     step_cnt, wrap, lockup);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] seq [6];
        seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
        cycle(1, 0, 1, 8'h00);
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (state !== seq[k] || out_bit !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL seq[%0d]: state=%h bit=%b valid=%b want %h/0/1",
                         k, state, out_bit, out_valid, seq[k]);
            end
            cycle(1, 0, 1, 8'h00);
        end
        n_tests++;
        if (state !== m_state || step_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL seq_model: state=%h cnt=%0d want %h/%0d",
                     state, step_cnt, m_state, m_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic r;
        for (int k = 0; k < 80; k++) begin
            r = 1'($urandom_range(0, 1));
            cycle(1, 0, r, 8'h00);
            n_tests++;
            if (pre_valid_dut !== pre_valid_exp || state !== m_state ||
                out_bit !== m_state[7] || step_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL bp[%0d]: valid=%b state=%h bit=%b cnt=%0d want %b/%h/%b/%0d",
                         k, pre_valid_dut, state, out_bit, step_cnt,
                         pre_valid_exp, m_state, m_state[7], m_cnt);
            end
        end
    endtask

    task automatic test_lockup();
        logic [7:0] s;
        cycle(1, 1, 1, 8'hFF);
        n_tests++;
        if (pre_valid_dut !== 1'b0) begin
            n_fail++; $display("FAIL load_gate: valid=%b want 0", pre_valid_dut);
        end
        n_tests++;
        if (state !== 8'h00 || lockup !== 1'b1 || step_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL lockup_ff: state=%h lockup=%b cnt=%0d want 00/1/0",
                     state, lockup, step_cnt);
        end
        cycle(1, 0, 0, 8'h00);
        n_tests++;
        if (lockup !== 1'b0) begin
            n_fail++; $display("FAIL lockup_pulse: lockup=%b want 0", lockup);
        end
        cycle(1, 1, 0, 8'h5A);
        n_tests++;
        if (state !== 8'h5A || lockup !== 1'b0) begin
            n_fail++;
            $display("FAIL load_5a: state=%h lockup=%b want 5a/0", state, lockup);
        end
        s = 8'($urandom_range(0, 254));
        cycle(1, 1, 0, s);
        repeat (5) cycle(1, 0, 1, 8'h00);
        n_tests++;
        if (state !== m_state || step_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL load_rand(%h): state=%h cnt=%0d want %h/%0d",
                     s, state, step_cnt, m_state, m_cnt);
        end
    endtask

    task automatic test_period();
        int n_wrap = 0;
        int wrap_at = -1;
        int n_ones = 0;
        cycle(1, 1, 1, 8'h00);
        for (int k = 1; k <= 255; k++) begin
            cycle(1, 0, 1, 8'h00);
            if (state === 8'hFF) n_ones++;
            if (wrap === 1'b1) begin
                n_wrap++;
                wrap_at = k;
            end
        end
        n_tests++;
        if (state !== 8'h00 || step_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL period_end: state=%h cnt=%0d want 00/0", state, step_cnt);
        end
        n_tests++;
        if (n_wrap !== 1 || wrap_at !== 255) begin
            n_fail++;
            $display("FAIL period_wrap: pulses=%0d at=%0d want 1 at 255",
                     n_wrap, wrap_at);
        end
        n_tests++;
        if (n_ones !== 0) begin
            n_fail++; $display("FAIL period_ones: seen=%0d want 0", n_ones);
        end
        cycle(1, 0, 0, 8'h00);
        n_tests++;
        if (wrap !== 1'b0) begin
            n_fail++; $display("FAIL wrap_pulse: wrap=%b want 0", wrap);
        end
    endtask

    task automatic test_load_wrap();
        cycle(1, 1, 1, 8'h00);
        repeat (254) cycle(1, 0, 1, 8'h00);
        n_tests++;
        if (step_cnt !== 8'd254) begin
            n_fail++; $display("FAIL pre_wrap_cnt: cnt=%0d want 254", step_cnt);
        end
        cycle(1, 1, 1, 8'h33);
        n_tests++;
        if (wrap !== 1'b0 || step_cnt !== 8'd0 || state !== 8'h33) begin
            n_fail++;
            $display("FAIL load_wrap: wrap=%b cnt=%0d state=%h want 0/0/33",
                     wrap, step_cnt, state);
        end
    endtask

    task automatic test_drain();
        logic [7:0] frozen;
        repeat (2) cycle(1, 0, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
        n_tests++;
        if (out_valid !== 1'b1 || state !== m_state) begin
            n_fail++;
            $display("FAIL drain_hold: valid=%b state=%h want 1/%h",
                     out_valid, state, m_state);
        end
        cycle(1, 0, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL drain_reen: valid=%b want 1", out_valid);
        end
        cycle(0, 0, 1, 8'h00);
        n_tests++;
        if (out_valid !== 1'b0 || state !== m_state || step_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL drain_xfer: valid=%b state=%h cnt=%0d want 0/%h/%0d",
                     out_valid, state, step_cnt, m_state, m_cnt);
        end
        frozen = state;
        repeat (3) cycle(0, 0, 1, 8'h00);
        n_tests++;
        if (state !== frozen || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_frozen: state=%h valid=%b want %h/0",
                     state, out_valid, frozen);
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 1, 0, 8'h3C);
        repeat (4) cycle(1, 0, 1, 8'h00);
        n_tests++;
        if (state === SEED || step_cnt === 8'd0) begin
            n_fail++;
            $display("FAIL prereset: state=%h cnt=%0d want non-reset", state, step_cnt);
        end
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (state !== SEED || out_valid !== 1'b0 || out_bit !== SEED[7] ||
            step_cnt !== 8'd0 || wrap !== 1'b0 || lockup !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: state=%h valid=%b bit=%b cnt=%0d w=%b l=%b",
                     state, out_valid, out_bit, step_cnt, wrap, lockup);
        end
        en = 1'b0; load = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        cycle(1, 0, 1, 8'h00);
        repeat (3) cycle(1, 0, 1, 8'h00);
        n_tests++;
        if (state !== m_state || step_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL post_rst: state=%h cnt=%0d want %h/%0d",
                     state, step_cnt, m_state, m_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_backpressure();
        test_lockup();
        test_period();
        test_load_wrap();
        test_drain();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
